// File: rtl/riscv_fetch_ctrl_if.sv
// Fetch-controller bus bundle: instruction-memory req/ack, redirect, and decode valid/ready.
// master = fetch controller side, slave = memory/consumer side.
interface riscv_fetch_ctrl_if;
  logic [29:0] inst_addr;
  logic        inst_req;
  logic        inst_ack;
  logic [31:0] inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  modport master (
    output inst_addr, inst_req, out_valid, out_inst, out_pc,
    input  inst_ack, inst, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  inst_addr, inst_req, out_valid, out_inst, out_pc,
    output inst_ack, inst, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/riscv_fetch_ctrl.sv
// Single-outstanding instruction fetch sequencer: owns the PC, fetches one word
// at a time, hands it to decode, and safely retires a fetch orphaned by a redirect.
module riscv_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  riscv_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {BOOT, FETCH, VALID, DROP} state_t;

  state_t      r_state, w_nxt_state;
  logic [31:0] r_pc, w_nxt_pc;
  logic [29:0] r_req_addr, w_nxt_req_addr;
  logic        r_inst_req, w_nxt_inst_req;
  logic        r_out_valid, w_nxt_out_valid;
  logic [31:0] r_out_inst, w_nxt_out_inst;
  logic [31:0] r_out_pc, w_nxt_out_pc;
  logic [31:0] w_target;

  assign w_target = bus.redirect_pc & ~32'h3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= BOOT;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC[31:2];
      r_inst_req  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_pc    <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_pc        <= w_nxt_pc;
      r_req_addr  <= w_nxt_req_addr;
      r_inst_req  <= w_nxt_inst_req;
      r_out_valid <= w_nxt_out_valid;
      r_out_inst  <= w_nxt_out_inst;
      r_out_pc    <= w_nxt_out_pc;
    end
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_pc        = r_pc;
    w_nxt_req_addr  = r_req_addr;
    w_nxt_out_valid = r_out_valid;
    w_nxt_out_inst  = r_out_inst;
    w_nxt_out_pc    = r_out_pc;
    if (bus.redirect_valid) w_nxt_pc = w_target;

    case (r_state)
      BOOT: begin
        w_nxt_req_addr = w_nxt_pc[31:2];
        w_nxt_state    = FETCH;
      end
      FETCH: begin
        if (bus.redirect_valid) begin
          // An un-acked request must still complete before the new target can go out.
          if (bus.inst_ack) w_nxt_req_addr = w_target[31:2];
          else              w_nxt_state    = DROP;
        end else if (bus.inst_ack) begin
          w_nxt_out_inst  = bus.inst;
          w_nxt_out_pc    = r_pc;
          w_nxt_out_valid = 1'b1;
          w_nxt_pc        = r_pc + 32'd4;
          w_nxt_state     = VALID;
        end
      end
      VALID: begin
        // Redirect overrides a same-cycle accept; the consumer ignores that transfer.
        if (bus.redirect_valid || bus.out_ready) begin
          w_nxt_out_valid = 1'b0;
          w_nxt_req_addr  = w_nxt_pc[31:2];
          w_nxt_state     = FETCH;
        end
      end
      DROP: begin
        if (bus.inst_ack) begin
          w_nxt_req_addr = w_nxt_pc[31:2];
          w_nxt_state    = FETCH;
        end
      end
      default: w_nxt_state = BOOT;
    endcase

    w_nxt_inst_req = (w_nxt_state == FETCH) || (w_nxt_state == DROP);
  end

  assign bus.inst_addr = r_req_addr;
  assign bus.inst_req  = r_inst_req;
  assign bus.out_valid = r_out_valid;
  assign bus.out_inst  = r_out_inst;
  assign bus.out_pc    = r_out_pc;

endmodule
